// File: rtl/cam_scan_engine.sv
// Purpose: 16-entry CAM scanned one entry per cycle against a latched key, reporting each match.
// Latency: full scan reports entry i at edge E(i+1) after start at E0; done in the cycle after E16.
// Backpressure: none; start is ignored while busy, and writes are accepted every cycle in any state.
//
// Ports:
//    clk, rst_n               clock, synchronous active-low reset
//    wen, addr, din           entry write (sets the entry valid bit)
//    start, key, first        search request, key and stop-on-first-match mode (sampled in IDLE only)
//    busy                     high while scanning
//    match_valid, match_addr  one-cycle strobe per matching entry, with its address
//    done                     one-cycle strobe after the scan ends
//    found, count             result of the last search, held until the next accepted start
module cam_scan_engine #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wen,
   input  logic [$clog2(DEPTH)-1:0]       addr,
   input  logic [WIDTH-1:0]               din,
   input  logic                           start,
   input  logic [WIDTH-1:0]               key,
   input  logic                           first,
   output logic                           busy,
   output logic                           match_valid,
   output logic [$clog2(DEPTH)-1:0]       match_addr,
   output logic                           done,
   output logic                           found,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [AW-1:0]    idx_q;
   logic [WIDTH-1:0] key_q;
   logic             first_q;
   logic             busy_q;
   logic             match_valid_q;
   logic [AW-1:0]    match_addr_q;
   logic             done_q;
   logic             found_q;
   logic [CW-1:0]    count_q;

   logic             hit;
   logic             last;
   logic [CW-1:0]    count_d;
   logic [AW-1:0]    idx_d;

   // The compare reads the registered storage, so a write landing on the same
   // edge is not seen by the entry evaluated at that edge; later entries see it.
   assign hit     = valid_q[idx_q] && (mem_q[idx_q] == key_q);
   assign last    = (idx_q == AW'(DEPTH - 1));
   assign count_d = count_q + CW'(1);
   assign idx_d   = idx_q + AW'(1);

   // Data array carries no reset; only the valid bits gate matching.
   always_ff @(posedge clk) begin
      if (rst_n && wen) begin
         mem_q[addr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         valid_q       <= '0;
         idx_q         <= '0;
         key_q         <= '0;
         first_q       <= 1'b0;
         busy_q        <= 1'b0;
         match_valid_q <= 1'b0;
         match_addr_q  <= '0;
         done_q        <= 1'b0;
         found_q       <= 1'b0;
         count_q       <= '0;
      end else begin
         match_valid_q <= 1'b0;
         done_q        <= 1'b0;

         if (wen) begin
            valid_q[addr] <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  key_q   <= key;
                  first_q <= first;
                  count_q <= '0;
                  found_q <= 1'b0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SCAN;
               end
            end

            S_SCAN: begin
               if (hit) begin
                  match_valid_q <= 1'b1;
                  match_addr_q  <= idx_q;
                  count_q       <= count_d;
                  found_q       <= 1'b1;
               end
               // Leave after the final entry, or at the first hit in first-match mode.
               if (last || (hit && first_q)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  idx_q <= idx_d;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign match_valid = match_valid_q;
   assign match_addr  = match_addr_q;
   assign done        = done_q;
   assign found       = found_q;
   assign count       = count_q;

endmodule

// File: tb/tb_cam_scan_engine.sv
// Purpose: directed self-checking bench for cam_scan_engine with a queue of expected match addresses.
// Latency: samples 1 time unit after each rising edge; scan edges counted from the start edge E0.
// Backpressure: not applicable; the bench drives all inputs directly.
module tb_cam_scan_engine;

   logic       clk;
   logic       rst_n;
   logic       wen;
   logic [3:0] addr;
   logic [7:0] din;
   logic       start;
   logic [7:0] key;
   logic       first;
   logic       busy;
   logic       match_valid;
   logic [3:0] match_addr;
   logic       done;
   logic       found;
   logic [4:0] count;

   int vecs;
   int errs;
   int exp_q[$];

   cam_scan_engine #(.DEPTH(16), .WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wen         (wen),
      .addr        (addr),
      .din         (din),
      .start       (start),
      .key         (key),
      .first       (first),
      .busy        (busy),
      .match_valid (match_valid),
      .match_addr  (match_addr),
      .done        (done),
      .found       (found),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vecs++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Advance one edge, then pop the scoreboard for any reported match.
   task automatic tick();
      @(posedge clk);
      #1;
      if (match_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_match_addr", {28'd0, match_addr}, 32'd99);
         end else begin
            check("match_addr", {28'd0, match_addr}, exp_q.pop_front());
         end
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      wen  = 1'b1;
      addr = a;
      din  = d;
      tick();
      wen  = 1'b0;
   endtask

   // One search starting at E0. exp_done is the edge after which done is high
   // (-1 when a reset aborts it at edge rc). sc = edge of an extra start pulse.
   // Up to two writes at edges wc0/wc1 (wc0 may be 0, coincident with start).
   task automatic scan(input logic [7:0] k, input logic f, input int exp_done, input int exp_cnt,
                       input int rc, input int sc,
                       input int wc0, input logic [3:0] wa0, input logic [7:0] wd0,
                       input int wc1, input logic [3:0] wa1, input logic [7:0] wd1);
      int last_n;
      int endc;
      last_n = (exp_done >= 0) ? exp_done + 2 : 20;
      endc   = (exp_done >= 0) ? exp_done : rc;
      start  = 1'b1;
      key    = k;
      first  = f;
      wen    = 1'b0;
      if (wc0 == 0) begin
         wen  = 1'b1;
         addr = wa0;
         din  = wd0;
      end
      for (int n = 0; n <= last_n; n++) begin
         tick();
         check("busy", {31'd0, busy}, {31'd0, (n < endc)});
         check("done", {31'd0, done}, {31'd0, (n == exp_done)});
         if (n == exp_done) begin
            check("count_at_done", {27'd0, count}, exp_cnt);
            check("found_at_done", {31'd0, found}, {31'd0, (exp_cnt != 0)});
         end
         // Inputs for edge E(n+1); key/first scrambled to prove they were latched.
         start = ((n + 1) == sc);
         key   = ~k;
         first = ~f;
         wen   = 1'b0;
         if ((n + 1) == wc0) begin
            wen  = 1'b1;
            addr = wa0;
            din  = wd0;
         end
         if ((n + 1) == wc1) begin
            wen  = 1'b1;
            addr = wa1;
            din  = wd1;
         end
         rst_n = !(((n + 1) >= rc) && ((n + 1) < rc + 2));
      end
      wen   = 1'b0;
      start = 1'b0;
      rst_n = 1'b1;
      check("missed_matches", exp_q.size(), 0);
      exp_q.delete();
      check("count_held", {27'd0, count}, exp_cnt);
      check("found_held", {31'd0, found}, {31'd0, (exp_cnt != 0)});
      check("busy_after", {31'd0, busy}, 0);
   endtask

   initial begin
      vecs  = 0;
      errs  = 0;
      rst_n = 1'b0;
      wen   = 1'b0;
      addr  = '0;
      din   = '0;
      start = 1'b0;
      key   = '0;
      first = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_busy",        {31'd0, busy},        0);
      check("rst_done",        {31'd0, done},        0);
      check("rst_match_valid", {31'd0, match_valid}, 0);
      check("rst_match_addr",  {28'd0, match_addr},  0);
      check("rst_count",       {27'd0, count},       0);
      check("rst_found",       {31'd0, found},       0);
      rst_n = 1'b1;
      tick();

      // All entries invalid: no match even for key 0
      scan(8'd0, 1'b0, 16, 0, -10, -10, -10, 4'd0, 8'd0, -10, 4'd0, 8'd0);

      wr(4'd0, 8'd4);
      wr(4'd7, 8'd8);
      wr(4'd15, 8'd35);
      wr(4'd9, 8'd8);
      wr(4'd5, 8'd8);

      // Full scan, three matches in ascending order
      exp_q.push_back(5);
      exp_q.push_back(7);
      exp_q.push_back(9);
      scan(8'd8, 1'b0, 16, 3, -10, -10, -10, 4'd0, 8'd0, -10, 4'd0, 8'd0);

      // No match; start pulse while in DONE is ignored
      scan(8'd87, 1'b0, 16, 0, -10, 17, -10, 4'd0, 8'd0, -10, 4'd0, 8'd0);

      // Match on the last entry, coincident with done
      exp_q.push_back(15);
      scan(8'd35, 1'b0, 16, 1, -10, -10, -10, 4'd0, 8'd0, -10, 4'd0, 8'd0);

      // Stop on first match
      exp_q.push_back(5);
      scan(8'd8, 1'b1, 6, 1, -10, -10, -10, 4'd0, 8'd0, -10, 4'd0, 8'd0);

      // Writes during scan: 12 (not yet evaluated) seen, 2 (already evaluated) not; mid-scan start ignored
      exp_q.push_back(5);
      exp_q.push_back(7);
      exp_q.push_back(9);
      exp_q.push_back(12);
      scan(8'd8, 1'b0, 16, 4, -10, 8, 3, 4'd12, 8'd8, 10, 4'd2, 8'd8);

      // Write and start on the same edge: scan sees the new entry 0
      exp_q.push_back(0);
      scan(8'd8, 1'b1, 1, 1, -10, -10, 0, 4'd0, 8'd8, -10, 4'd0, 8'd0);

      // Reset at E5 aborts the scan after matches at 0 and 2
      exp_q.push_back(0);
      exp_q.push_back(2);
      scan(8'd8, 1'b0, -1, 0, 5, -10, -10, 4'd0, 8'd0, -10, 4'd0, 8'd0);

      // Reset cleared every valid bit
      scan(8'd8, 1'b0, 16, 0, -10, -10, -10, 4'd0, 8'd0, -10, 4'd0, 8'd0);

      // Sixteen matches give count 16 without wrap
      for (int i = 0; i < 16; i++) begin
         wr(4'(i), 8'hAA);
      end
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(i);
      end
      scan(8'hAA, 1'b0, 16, 16, -10, -10, -10, 4'd0, 8'd0, -10, 4'd0, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/cam_scan_engine.md
CAM_SCAN_ENGINE -- requirements
Module: cam_scan_engine

Interface
REQ-001 The block SHALL have the parameters DEPTH = 16 (number of entries) and WIDTH = 8 (data width in bits); both are fixed for this revision.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 wen  input  1  write enable; stores din at addr.
REQ-005 addr  input  4  write address.
REQ-006 din  input  8  write data.
REQ-007 start  input  1  search request; sampled only in IDLE.
REQ-008 key  input  8  search value; latched when start is accepted.
REQ-009 first  input  1  stop-on-first-match mode; latched when start is accepted.
REQ-010 busy  output  1  high while in SCAN.
REQ-011 match_valid  output  1  one-cycle strobe, one per matching entry.
REQ-012 match_addr  output  4  address of the reported match; meaningful only when match_valid=1.
REQ-013 done  output  1  one-cycle strobe at the end of a search.
REQ-014 found  output  1  at least one match in the last search; held until the next accepted start.
REQ-015 count  output  5  number of matches in the last search (0..16); held until the next accepted start.

Function
REQ-016 Storage SHALL be 16 x 8-bit entries, each with a valid bit; an entry whose valid bit is 0 SHALL never match.
REQ-017 When wen=1 at an edge, the block SHALL write mem[addr]<=din and set valid[addr]<=1, in any state.
REQ-018 The FSM SHALL have the states IDLE, SCAN and DONE; reset SHALL enter IDLE.
REQ-019 IDLE: when start=1 at edge E0, the block SHALL latch key and first, clear count/found, set idx=0 and go to SCAN; otherwise it SHALL stay in IDLE.
REQ-020 SCAN: at edge E(i+1), entry i SHALL be compared against the latched key using the storage contents as they stand before that same edge's write.
REQ-021 On a match at entry i, the block SHALL register match_valid=1, match_addr=i and count+1 at the same edge.
REQ-022 SCAN SHALL exit to DONE at the edge that evaluates entry 15, or, when first=1, at the edge of the first match.
REQ-023 In a full scan, match_valid SHALL report matches in strictly ascending address order.
REQ-024 done SHALL be high for exactly the one cycle following the exit edge; DONE SHALL return to IDLE at the next edge.
REQ-025 found SHALL equal (count != 0) when done is high.
REQ-026 Latency: a full scan SHALL have start sampled at E0, done high in the cycle after E16, and busy high from after E0 through the E16 edge.
REQ-027 start SHALL be ignored while in SCAN or DONE.
REQ-028 key and first SHALL be ignored except in the accepted-start cycle.
REQ-029 When wen and start occur at the same edge in IDLE, both SHALL take effect, and the scan SHALL see the newly written entry.
REQ-030 A write to entry j during SCAN SHALL be visible to the scan if and only if j has not yet been evaluated.
REQ-031 count SHALL be 5 bits wide; 16 matches SHALL yield count=16, with no wrap.

Reset
REQ-032 When rst_n=0 at an edge, the block SHALL go to IDLE and clear all valid bits, idx, count, found, busy, match_valid, match_addr and done to 0; mem data SHALL be don't-care.
REQ-033 Reset SHALL take priority over wen and start at the same edge.
REQ-034 Reset mid-SCAN SHALL abort the search with no done pulse; the first edge with rst_n=1 SHALL behave as IDLE.

Verification
REQ-035 Write 4@0, 8@7, 35@15, 8@9, 8@5; then start key=8, first=0 -> match_valid with match_addr 5, 7, 9 in order; done in the cycle after E16; count=3; found=1.
REQ-036 Using the same contents, start key=87 -> no match_valid; done after 16 cycles; count=0; found=0; key=35 -> single match at 15, coincident with done.
REQ-037 Using the same contents, start key=8, first=1 -> one match_valid with addr 5; done in the cycle after E6; count=1; busy low afterwards.
REQ-038 After reset, start key=0 -> no matches (all entries invalid); count=0.
REQ-039 During a key=8 scan, write 8@12 at E3 and 8@2 at E10 -> entry 12 reported and entry 2 not reported; count=4; start pulsed mid-scan has no effect.
REQ-040 Apply rst_n=0 at E5 of a scan -> busy=0, done never asserted, count=0, and a subsequent key=8 search returns count=0.
